// File: rtl/euclid_square_diff.sv
// Squares |px-cx| and |py-cy| with two lockstep serial shift-and-add multipliers.
// Optional EUCLID_SQ_EARLY_EXIT_EN: leave MUL once both remaining multipliers are zero.
module euclid_square_diff #(
  parameter int unsigned COORD_W = 16
) (
  input  logic                   sq_clk,
  input  logic                   sq_rst,
  input  logic                   start,
  input  logic [COORD_W-1:0]     px,
  input  logic [COORD_W-1:0]     py,
  input  logic [COORD_W-1:0]     cx,
  input  logic [COORD_W-1:0]     cy,
  output logic                   busy,
  output logic                   valid,
  output logic [2*COORD_W-1:0]   dx2,
  output logic [2*COORD_W-1:0]   dy2
);

  localparam int unsigned PW   = 2 * COORD_W;
  localparam int unsigned CntW = (COORD_W > 1) ? $clog2(COORD_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(COORD_W - 1);

  typedef enum logic [1:0] {StIdle, StDiff, StMul, StDone} state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   px_q, px_d, py_q, py_d, cx_q, cx_d, cy_q, cy_d;
  logic [PW-1:0]        mcand_x_q, mcand_x_d, mcand_y_q, mcand_y_d;
  logic [COORD_W-1:0]   mplier_x_q, mplier_x_d, mplier_y_q, mplier_y_d;
  logic [PW-1:0]        acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d, valid_q, valid_d;
  logic [PW-1:0]        dx2_q, dx2_d, dy2_q, dy2_d;

  logic [COORD_W-1:0]   mx, my;
  logic [COORD_W-1:0]   mplier_x_sh, mplier_y_sh;
  logic                 mul_last;

  // Larger minus smaller keeps the difference within COORD_W bits unsigned.
  always_comb begin
    mx = (px_q >= cx_q) ? (px_q - cx_q) : (cx_q - px_q);
    my = (py_q >= cy_q) ? (py_q - cy_q) : (cy_q - py_q);
  end

  always_comb begin
    mplier_x_sh = mplier_x_q >> 1;
    mplier_y_sh = mplier_y_q >> 1;
`ifdef EUCLID_SQ_EARLY_EXIT_EN
    mul_last = (cnt_q == CntLast) ||
               ((mplier_x_sh == '0) && (mplier_y_sh == '0));
`else
    mul_last = (cnt_q == CntLast);
`endif
  end

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    mcand_x_d  = mcand_x_q;
    mcand_y_d  = mcand_y_q;
    mplier_x_d = mplier_x_q;
    mplier_y_d = mplier_y_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    dx2_d      = dx2_q;
    dy2_d      = dy2_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          px_d    = px;
          py_d    = py;
          cx_d    = cx;
          cy_d    = cy;
          busy_d  = 1'b1;
          state_d = StDiff;
        end
      end

      StDiff: begin
        mcand_x_d  = {{COORD_W{1'b0}}, mx};
        mcand_y_d  = {{COORD_W{1'b0}}, my};
        mplier_x_d = mx;
        mplier_y_d = my;
        acc_x_d    = '0;
        acc_y_d    = '0;
        cnt_d      = '0;
        busy_d     = 1'b1;
        state_d    = StMul;
`ifdef EUCLID_SQ_EARLY_EXIT_EN
        if ((mx == '0) && (my == '0)) begin
          busy_d  = 1'b0;
          state_d = StDone;
        end
`endif
      end

      StMul: begin
        if (mplier_x_q[0]) acc_x_d = acc_x_q + mcand_x_q;
        if (mplier_y_q[0]) acc_y_d = acc_y_q + mcand_y_q;
        mcand_x_d  = {mcand_x_q[PW-2:0], 1'b0};
        mcand_y_d  = {mcand_y_q[PW-2:0], 1'b0};
        mplier_x_d = mplier_x_sh;
        mplier_y_d = mplier_y_sh;
        cnt_d      = cnt_q + CntW'(1);
        if (mul_last) begin
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end

      StDone: begin
        dx2_d   = acc_x_q;
        dy2_d   = acc_y_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        // A start here is accepted directly, giving back-to-back jobs.
        if (start) begin
          px_d    = px;
          py_d    = py;
          cx_d    = cx;
          cy_d    = cy;
          busy_d  = 1'b1;
          state_d = StDiff;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sq_clk) begin
    if (sq_rst) begin
      state_q    <= StIdle;
      px_q       <= '0;
      py_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      mcand_x_q  <= '0;
      mcand_y_q  <= '0;
      mplier_x_q <= '0;
      mplier_y_q <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      dx2_q      <= '0;
      dy2_q      <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      mcand_x_q  <= mcand_x_d;
      mcand_y_q  <= mcand_y_d;
      mplier_x_q <= mplier_x_d;
      mplier_y_q <= mplier_y_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      dx2_q      <= dx2_d;
      dy2_q      <= dy2_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign dx2   = dx2_q;
  assign dy2   = dy2_q;

endmodule

// File: tb/tb_euclid_square_diff.sv
// Scoreboard bench for euclid_square_diff: stimulus pushes expected results, a monitor pops them.
module tb_euclid_square_diff;
  localparam int unsigned CW = 16;

  logic          sq_clk = 1'b0;
  logic          sq_rst = 1'b1;
  logic          start  = 1'b0;
  logic [CW-1:0] px = '0, py = '0, cx = '0, cy = '0;
  logic          busy, valid;
  logic [2*CW-1:0] dx2, dy2;

  euclid_square_diff #(.COORD_W(CW)) dut (
    .sq_clk (sq_clk),
    .sq_rst (sq_rst),
    .start  (start),
    .px     (px),
    .py     (py),
    .cx     (cx),
    .cy     (cy),
    .busy   (busy),
    .valid  (valid),
    .dx2    (dx2),
    .dy2    (dy2)
  );

  always #5 sq_clk = ~sq_clk;

  typedef struct {
    logic [31:0] dx2;
    logic [31:0] dy2;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge sq_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Cycles from the start-sampling edge to the edge that raises valid.
  function automatic int unsigned lat(input logic [CW-1:0] ipx, input logic [CW-1:0] ipy,
                                      input logic [CW-1:0] icx, input logic [CW-1:0] icy);
`ifdef EUCLID_SQ_EARLY_EXIT_EN
    logic [CW-1:0] mx, my, m;
    int hb;
    mx = absdiff(ipx, icx);
    my = absdiff(ipy, icy);
    m  = (mx > my) ? mx : my;
    if (m == '0) return 2;
    hb = 0;
    for (int i = 0; i < CW; i++) if (m[i]) hb = i;
    return 3 + hb;
`else
    return CW + 2;
`endif
  endfunction

  task automatic tick();
    @(posedge sq_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ex, input logic [31:0] ey, input int unsigned due);
    exp_t e;
    e.dx2 = ex;
    e.dy2 = ey;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    tick();
    tick();
  endtask

  task automatic run_job(input logic [CW-1:0] ipx, input logic [CW-1:0] ipy,
                         input logic [CW-1:0] icx, input logic [CW-1:0] icy,
                         input logic [31:0] ex, input logic [31:0] ey);
    px = ipx; py = ipy; cx = icx; cy = icy;
    start = 1'b1;
    push(ex, ey, cyc + 1 + lat(ipx, ipy, icx, icy));
    tick();
    start = 1'b0;
    check("busy_after_start", {32'd0, busy}, 33'd1);
    drain();
  endtask

  // Monitor: every valid pulse must match the oldest expectation at its due cycle.
  always @(negedge sq_clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got valid=1 dx2=0x%0h dy2=0x%0h, expected no pulse (cycle %0d)",
                 dx2, dy2, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("dx2", {1'b0, dx2}, {1'b0, mon_e.dx2});
        check("dy2", {1'b0, dy2}, {1'b0, mon_e.dy2});
        check("adder_sum", {1'b0, dx2} + {1'b0, dy2}, {1'b0, mon_e.dx2} + {1'b0, mon_e.dy2});
        check("latency", 33'(cyc), 33'(mon_e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      tests++;
      fails++;
      $display("FAIL missing_valid: got no pulse by cycle %0d, expected one at cycle %0d",
               cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    int unsigned due_a;

    // Reset held with random inputs and start asserted.
    sq_rst = 1'b1;
    start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      px = 16'($urandom); py = 16'($urandom); cx = 16'($urandom); cy = 16'($urandom);
      tick();
      check("rst_busy",  {32'd0, busy},  33'd0);
      check("rst_valid", {32'd0, valid}, 33'd0);
      check("rst_dx2",   {1'b0, dx2},    33'd0);
      check("rst_dy2",   {1'b0, dy2},    33'd0);
    end
    start  = 1'b0;
    sq_rst = 1'b0;
    tick();

    // Basic vector: 3^2 and 4^2, sum 25.
    run_job(16'd10, 16'd3, 16'd7, 16'd7, 32'd9, 32'd16);
    // Full-scale differences in both directions.
    run_job(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 32'hFFFE0001, 32'hFFFE0001);
    // Swapped ordering gives identical squares.
    run_job(16'd3, 16'd7, 16'd7, 16'd3, 32'd16, 32'd16);
    // Equal coordinates give zero.
    run_job(16'd1234, 16'd5, 16'd1234, 16'd5, 32'd0, 32'd0);
    // Single high bit and single low bit.
    run_job(16'h8000, 16'd1, 16'd0, 16'd0, 32'h40000000, 32'd1);
    run_job(16'd300, 16'd0, 16'd44, 16'd255, 32'd65536, 32'd65025);

    // A start while busy is ignored.
    px = 16'd5; cx = 16'd1; py = 16'd0; cy = 16'd0;
    start = 1'b1;
    push(32'd16, 32'd0, cyc + 1 + lat(16'd5, 16'd0, 16'd1, 16'd0));
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    px = 16'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    px = 16'd5;
    drain();
    for (int i = 0; i < 20; i++) tick();

    // Reset aborts a job in flight.
    px = 16'd1000; cx = 16'd0; py = 16'd0; cy = 16'd0;
    start = 1'b1;
    push(32'd1000000, 32'd0, cyc + 1 + lat(16'd1000, 16'd0, 16'd0, 16'd0));
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    sq_rst = 1'b1;
    tick();
    sq_rst = 1'b0;
    sb.delete();
    check("abort_busy",  {32'd0, busy},  33'd0);
    check("abort_valid", {32'd0, valid}, 33'd0);
    check("abort_dx2",   {1'b0, dx2},    33'd0);
    check("abort_dy2",   {1'b0, dy2},    33'd0);
    for (int i = 0; i < 20; i++) tick();

    // Back-to-back: start held high, second vector taken in DONE.
    px = 16'd2; cx = 16'd0; py = 16'd3; cy = 16'd0;
    start = 1'b1;
    due_a = cyc + 1 + lat(16'd2, 16'd3, 16'd0, 16'd0);
    push(32'd4, 32'd9, due_a);
    push(32'd16, 32'd1, due_a + lat(16'd4, 16'd0, 16'd0, 16'd1));
    tick();
    px = 16'd4; cx = 16'd0; py = 16'd0; cy = 16'd1;
    for (int i = 0; i < 100 && cyc < due_a; i++) tick();
    start = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) tick();

    check("scoreboard_empty", 33'(sb.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/euclid_square_diff.md
Name: euclid_square_diff

Overview:
- Upstream stage of the Euclidean-distance datapath in the Kmeans core.
- Takes one sample point (px,py) and one centroid (cx,cy), forms |px-cx| and |py-cy|, and squares both with a serial shift-and-add multiplier.
- Emits dx2/dy2 as the two 32-bit operands of the downstream 32-bit ripple adder, which produces dx2+dy2.

Parameters:
COORD_W, 16, unsigned coordinate width; product width is 2*COORD_W (32 at default, matching the adder operands).

Ports:
sq_clk  input  1  sole clock, rising edge.
sq_rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
px  input  COORD_W  point X, unsigned.
py  input  COORD_W  point Y, unsigned.
cx  input  COORD_W  centroid X, unsigned.
cy  input  COORD_W  centroid Y, unsigned.
busy  output  1  high while a computation is in flight.
valid  output  1  one-cycle pulse; dx2/dy2 are final.
dx2  output  2*COORD_W  (px-cx)^2; feeds adder operand a.
dy2  output  2*COORD_W  (py-cy)^2; feeds adder operand b.

Behaviour:
- One clock (sq_clk); synchronous active-high reset (sq_rst). All state and outputs are registers.
- Reset values: state=IDLE, busy=0, valid=0, dx2=0, dy2=0, internal accumulators, shift registers and counter all 0.
- States:
  - IDLE: start=1 latches px,py,cx,cy and moves to DIFF.
  - DIFF (1 cycle): mx=|px-cx|, my=|py-cy|. Compute as larger minus smaller, so the result fits COORD_W bits unsigned. Load multiplicand=multiplier=mx (likewise my), clear accumulators and cnt, go to MUL.
  - MUL (COORD_W cycles): each cycle, if the multiplier LSB=1, add multiplicand to the accumulator. Then shift the multiplicand left 1 (2*COORD_W wide) and the multiplier right 1, and increment cnt. X and Y run in lockstep. Leave when cnt reaches COORD_W-1.
  - DONE (1 cycle): dx2/dy2 <= accumulators, valid=1, busy=0. Next state is IDLE, or DIFF if start=1 (back-to-back accepted).
- busy=1 in DIFF and MUL only. start is ignored while busy=1: no relatch, no restart, no error.
- Latency: start sampled at edge N gives valid=1 during the cycle after edge N+COORD_W+2, which is 18 cycles at default. Throughput is one result per COORD_W+2 cycles.
- dx2/dy2 hold their last value until the next DONE. They never show partial products.
- Arithmetic: results are exact. Max square (2^COORD_W-1)^2 fits 2*COORD_W bits, so the block never overflows. dx2+dy2 can exceed 32 bits; that overflow appears on the adder's top carry-out and is not handled here.
- Equal coordinates give 0. The swap ordering makes px<cx and px>cx give identical results.
- sq_rst asserted in any state: next cycle is IDLE with all reset values. No valid pulse for the aborted job. Reset has priority over start in the same cycle.

Optional Feature:
- Macro: EUCLID_SQ_EARLY_EXIT_EN.
- Defined: MUL also exits to DONE as soon as both remaining multipliers are 0, checked after the shift. Latency is variable: 3 + index of the highest set bit of max(mx,my) cycles. When mx=my=0, DIFF goes directly to DONE (2 cycles). Results are bit-identical to the non-macro build.
- Undefined: fixed COORD_W+2 latency as above.

Test Plan:
1. Hold sq_rst=1 for 3 cycles with random inputs and start=1 -> busy=0, valid=0, dx2=0, dy2=0 throughout.
2. px=10,cx=7,py=3,cy=7, start pulse -> valid exactly 18 cycles later, dx2=9, dy2=16. The downstream adder then yields 25.
3. px=65535,cx=0,py=0,cy=65535 -> dx2=dy2=0xFFFE0001. Adder sum 0xFFFC0002 with carry-out 1.
4. Start job A (px=5,cx=1,py=0,cy=0), then pulse start with px=100 at cycle 4 -> the second start is ignored; dx2=16, dy2=0; only one valid pulse.
5. Start a job, assert sq_rst at cycle 6 for 1 cycle -> busy=0 and outputs 0 on the next cycle; no valid pulse for 20 cycles.
6. Back-to-back: hold start=1 with (2,0,3,0) then (4,0,0,1) -> valids 18 cycles apart: (4,9) then (16,1). With EUCLID_SQ_EARLY_EXIT_EN, the first job (max diff 3) gives valid 4 cycles after start.
